pitch_period_scheduler: RTL

//  Time-shares one pitch_to_sample_period converter (fixed 3-cycle latency) across NUM_VOICES drum voices.
//  - Latches per-voice pitch update requests.
//  - Grants one pending voice per cycle, round-robin, and drives that pitch into the converter.
//  - Tags each issue and writes the returned period into a per-voice register bank.
//  - Sits between the per-voice pot/ADC front end and the per-voice sample-rate counters.

---
 rtl/pitch_period_scheduler.sv | 118 +++++++++++
 1 files changed

// File: rtl/pitch_period_scheduler.sv
// Round-robin scheduler sharing one pitch->period converter across NUM_VOICES voices.
// Optional: PITCH_SCHED_REFRESH_EN issues a background refresh of the rr voice when nothing is pending.
module pitch_period_scheduler #(
  parameter  int          NUM_VOICES   = 8,
  parameter  int          CONV_LATENCY = 3,
  parameter  logic [13:0] RESET_PERIOD = 14'd2272,
  localparam int          VW           = $clog2(NUM_VOICES)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_VOICES*10-1:0]   pitch_in,
  input  logic [NUM_VOICES-1:0]      pitch_update,
  output logic [9:0]                 conv_pitch,
  input  logic [13:0]                conv_period,
  output logic [NUM_VOICES*14-1:0]   period_out,
  output logic [NUM_VOICES-1:0]      period_valid,
  output logic                       period_strobe,
  output logic [VW-1:0]              done_voice,
  output logic                       busy
);

  localparam logic [VW:0] NV   = (VW+1)'(NUM_VOICES);
  localparam int          LAST = CONV_LATENCY - 1;

  logic [NUM_VOICES-1:0] pending;
  logic [NUM_VOICES-1:0] pending_nxt;
  logic [NUM_VOICES-1:0] req;
  logic [NUM_VOICES-1:0] gnt_onehot;
  logic [VW-1:0]         rr_ptr;
  logic [VW-1:0]         gnt_idx;
  logic [VW-1:0]         cand;
  logic                  issue;

  // Stage 0 is loaded together with conv_pitch; conv_period carries the result
  // of the tag in stage LAST, and period_strobe/done_voice act as the final stage.
  logic [CONV_LATENCY-1:0] tag_v;
  logic [VW-1:0]           tag_id [CONV_LATENCY];

  function automatic logic [VW-1:0] wrap_add(input logic [VW-1:0] base, input logic [VW:0] off);
    logic [VW:0] s;
    s = {1'b0, base} + off;
    if (s >= NV) s = s - NV;
    return s[VW-1:0];
  endfunction

  always_comb begin
    req     = pending | pitch_update;
    issue   = 1'b0;
    gnt_idx = rr_ptr;
    cand    = rr_ptr;
    // Descending scan so the smallest offset from rr_ptr is the one that sticks.
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      cand = wrap_add(rr_ptr, (VW+1)'(i));
      if (req[cand]) begin
        issue   = 1'b1;
        gnt_idx = cand;
      end
    end
`ifdef PITCH_SCHED_REFRESH_EN
    if (!issue) begin
      issue   = 1'b1;
      gnt_idx = rr_ptr;
    end
`else
`endif
  end

  always_comb begin
    gnt_onehot = '0;
    if (issue) gnt_onehot[gnt_idx] = 1'b1;
    // A fresh update on an already-pending voice survives its own grant.
    pending_nxt = (req & ~gnt_onehot) | (pitch_update & pending & gnt_onehot);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending    <= '0;
      rr_ptr     <= '0;
      conv_pitch <= '0;
    end else begin
      pending <= pending_nxt;
      if (issue) begin
        rr_ptr     <= wrap_add(gnt_idx, (VW+1)'(1));
        conv_pitch <= pitch_in[int'(gnt_idx)*10 +: 10];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_v <= '0;
      for (int k = 0; k < CONV_LATENCY; k++) tag_id[k] <= '0;
    end else begin
      tag_v     <= {tag_v[CONV_LATENCY-2:0], issue};
      tag_id[0] <= gnt_idx;
      for (int k = 1; k < CONV_LATENCY; k++) tag_id[k] <= tag_id[k-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_out    <= {NUM_VOICES{RESET_PERIOD}};
      period_valid  <= '0;
      period_strobe <= 1'b0;
      done_voice    <= '0;
    end else begin
      period_strobe <= tag_v[LAST];
      if (tag_v[LAST]) begin
        done_voice                              <= tag_id[LAST];
        period_out[int'(tag_id[LAST])*14 +: 14] <= conv_period;
        period_valid[tag_id[LAST]]              <= 1'b1;
      end
    end
  end

  assign busy = (|pending) | (|tag_v);

endmodule
